// File: rtl/rat_ckpt_pkg.sv
// Shared configuration and types for the register alias table with branch checkpoints.
// The assertion checker is only compiled when RAT_ASSERT_EN is defined.
package rat_ckpt_pkg;
    localparam int NUM_AREGS    = 32;
    localparam int NUM_PREGS    = 64;
    localparam int RENAME_WIDTH = 2;
    localparam int NUM_CKPTS    = 4;

    localparam int AW = $clog2(NUM_AREGS);
    localparam int PW = $clog2(NUM_PREGS);
    localparam int CW = $clog2(NUM_CKPTS);

    typedef logic [AW-1:0] areg_t;
    typedef logic [PW-1:0] preg_t;
    typedef logic [CW-1:0] ckpt_id_t;
    typedef logic [CW:0]   ckpt_cnt_t;
    typedef preg_t         map_tbl_t [NUM_AREGS];

    // Forward distance from one ring slot to another; NUM_CKPTS is a power of two
    function automatic ckpt_id_t ring_dist(ckpt_id_t from_id, ckpt_id_t to_id);
        return ckpt_id_t'(to_id - from_id);
    endfunction
endpackage

// File: rtl/rat_ckpt_if.sv
// Rename-group, checkpoint-release and restore signals of the alias table.
interface rat_ckpt_if;
    import rat_ckpt_pkg::*;

    logic                         rn_fire;
    logic                         rn_ready;
    logic [RENAME_WIDTH*2*AW-1:0] rn_src_areg;
    logic [RENAME_WIDTH*2*PW-1:0] rn_src_preg;
    logic [RENAME_WIDTH-1:0]      rn_dst_wen;
    logic [RENAME_WIDTH*AW-1:0]   rn_dst_areg;
    logic [RENAME_WIDTH*PW-1:0]   rn_new_preg;
    logic [RENAME_WIDTH*PW-1:0]   rn_old_preg;
    logic [RENAME_WIDTH-1:0]      rn_ckpt_req;
    logic [CW-1:0]                rn_ckpt_id;
    logic                         ckpt_release;
    logic                         restore_valid;
    logic [CW-1:0]                restore_id;
    logic [CW:0]                  ckpt_count;

    modport master (
        output rn_fire, rn_src_areg, rn_dst_wen, rn_dst_areg, rn_new_preg,
               rn_ckpt_req, ckpt_release, restore_valid, restore_id,
        input  rn_ready, rn_src_preg, rn_old_preg, rn_ckpt_id, ckpt_count
    );

    modport slave (
        input  rn_fire, rn_src_areg, rn_dst_wen, rn_dst_areg, rn_new_preg,
               rn_ckpt_req, ckpt_release, restore_valid, restore_id,
        output rn_ready, rn_src_preg, rn_old_preg, rn_ckpt_id, ckpt_count
    );
endinterface

// File: rtl/rat_ckpt_chk.sv
// Protocol checker for rat_ckpt; compiled only when RAT_ASSERT_EN is defined.
`ifdef RAT_ASSERT_EN
module rat_ckpt_chk
    import rat_ckpt_pkg::*;
(
    input logic                       clk,
    input logic                       rst,
    input logic                       fire,
    input logic                       ready,
    input logic [RENAME_WIDTH-1:0]    ckpt_req,
    input logic                       ckpt_release,
    input logic                       restore_valid,
    input ckpt_id_t                   restore_id,
    input ckpt_id_t                   head,
    input ckpt_cnt_t                  count,
    input logic [RENAME_WIDTH-1:0]    dst_wen,
    input logic [RENAME_WIDTH*PW-1:0] new_preg,
    input map_tbl_t                   table_i
);
    logic hit_s;

    // A low new preg that is still present somewhere in the table is a double mapping
    always_comb begin
        hit_s = 1'b0;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            for (int a = 0; a < NUM_AREGS; a++) begin
                hit_s = hit_s | (dst_wen[k] &&
                                 (new_preg[k*PW +: PW] < preg_t'(NUM_AREGS)) &&
                                 (table_i[a] == new_preg[k*PW +: PW]));
            end
        end
    end

    a_fire_ready: assert property (@(posedge clk) disable iff (rst) fire |-> ready)
        else $error("rn_fire while not ready");
    a_one_req: assert property (@(posedge clk) disable iff (rst) $countones(ckpt_req) <= 1)
        else $error("multiple rn_ckpt_req bits");
    a_rel_empty: assert property (@(posedge clk) disable iff (rst)
        ckpt_release |-> (count != ckpt_cnt_t'(0)))
        else $error("ckpt_release with no live checkpoint");
    a_restore_live: assert property (@(posedge clk) disable iff (rst)
        restore_valid |-> ({1'b0, ring_dist(head, restore_id)} < count))
        else $error("restore_id is not live");
    a_preg_free: assert property (@(posedge clk) disable iff (rst)
        (fire && !restore_valid) |-> !hit_s)
        else $error("new preg still mapped");
endmodule
`endif

// File: rtl/rat_ckpt_ctrl.sv
// Checkpoint ring pointers: head/tail/count, ready, and release/restore ordering.
module rat_ckpt_ctrl
    import rat_ckpt_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      fire_i,
    input  logic      any_req_i,
    input  logic      release_i,
    input  logic      restore_valid_i,
    input  ckpt_id_t  restore_id_i,
    output logic      ready_o,
    output logic      alloc_o,
    output ckpt_id_t  head_o,
    output ckpt_id_t  tail_o,
    output ckpt_cnt_t count_o
);
    localparam ckpt_cnt_t FULL_CNT = ckpt_cnt_t'(NUM_CKPTS);

    ckpt_id_t  head_q, head_d;
    ckpt_id_t  tail_q, tail_d;
    ckpt_cnt_t count_q, count_d;
    logic      rel_s;

    // Acceptance, allocation and effective release (release on empty is dropped)
    always_comb begin
        ready_o = !((count_q == FULL_CNT) && any_req_i);
        alloc_o = fire_i && any_req_i && !restore_valid_i;
        rel_s   = release_i && (count_q != ckpt_cnt_t'(0));
    end

    // Release first, then a restore rebuilds tail and count from the updated head
    always_comb begin
        head_d  = rel_s ? ckpt_id_t'(head_q + ckpt_id_t'(1)) : head_q;
        count_d = rel_s ? ckpt_cnt_t'(count_q - ckpt_cnt_t'(1)) : count_q;
        tail_d  = tail_q;
        if (restore_valid_i) begin
            tail_d  = ckpt_id_t'(restore_id_i + ckpt_id_t'(1));
            count_d = ckpt_cnt_t'({1'b0, ring_dist(head_d, restore_id_i)} + ckpt_cnt_t'(1));
        end else if (alloc_o) begin
            tail_d  = ckpt_id_t'(tail_q + ckpt_id_t'(1));
            count_d = ckpt_cnt_t'(count_d + ckpt_cnt_t'(1));
        end else begin
            tail_d  = tail_q;
        end
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= ckpt_id_t'(0);
            tail_q  <= ckpt_id_t'(0);
            count_q <= ckpt_cnt_t'(0);
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;
endmodule

// File: rtl/rat_ckpt.sv
// Register alias table with intra-group bypass and NUM_CKPTS branch snapshots.
// Defining RAT_ASSERT_EN binds the rat_ckpt_chk protocol checker.
module rat_ckpt
    import rat_ckpt_pkg::*;
(
    input logic       clk,
    input logic       rst,
    rat_ckpt_if.slave rif
);
    map_tbl_t  table_q, table_d;
    map_tbl_t  snap_q [NUM_CKPTS];
    map_tbl_t  snap_d [NUM_CKPTS];
    map_tbl_t  ckpt_tbl_s;

    areg_t     src_areg_s [RENAME_WIDTH][2];
    areg_t     dst_areg_s [RENAME_WIDTH];
    preg_t     new_preg_s [RENAME_WIDTH];
    logic [RENAME_WIDTH*2*PW-1:0] src_flat_s;
    logic [RENAME_WIDTH*PW-1:0]   old_flat_s;

    logic      ready_s, alloc_s;
    ckpt_id_t  head_s, tail_s;
    ckpt_cnt_t count_s;

    // Unpack the flat lane vectors
    always_comb begin
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            dst_areg_s[k]    = rif.rn_dst_areg[k*AW +: AW];
            new_preg_s[k]    = rif.rn_new_preg[k*PW +: PW];
            src_areg_s[k][0] = rif.rn_src_areg[(k*2)*AW +: AW];
            src_areg_s[k][1] = rif.rn_src_areg[(k*2+1)*AW +: AW];
        end
    end

    // Lookups: the youngest older lane writing the same areg overrides the table
    always_comb begin
        preg_t p;
        p          = preg_t'(0);
        src_flat_s = '0;
        old_flat_s = '0;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            for (int s = 0; s < 2; s++) begin
                p = table_q[src_areg_s[k][s]];
                for (int j = 0; j < RENAME_WIDTH; j++) begin
                    p = ((j < k) && rif.rn_dst_wen[j] && (dst_areg_s[j] == src_areg_s[k][s]))
                        ? new_preg_s[j] : p;
                end
                src_flat_s[(k*2+s)*PW +: PW] = p;
            end
            p = table_q[dst_areg_s[k]];
            for (int j = 0; j < RENAME_WIDTH; j++) begin
                p = ((j < k) && rif.rn_dst_wen[j] && (dst_areg_s[j] == dst_areg_s[k]))
                    ? new_preg_s[j] : p;
            end
            old_flat_s[k*PW +: PW] = p;
        end
    end

    // Apply lanes in order (highest lane wins) and capture the branch lane's view
    always_comb begin
        map_tbl_t work;
        map_tbl_t cap;
        work = table_q;
        cap  = table_q;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            work[dst_areg_s[k]] = rif.rn_dst_wen[k] ? new_preg_s[k] : work[dst_areg_s[k]];
            for (int a = 0; a < NUM_AREGS; a++) begin
                cap[a] = rif.rn_ckpt_req[k] ? work[a] : cap[a];
            end
        end
        ckpt_tbl_s = cap;
        if (rif.restore_valid) begin
            table_d = snap_q[rif.restore_id];
        end else if (rif.rn_fire) begin
            table_d = work;
        end else begin
            table_d = table_q;
        end
    end

    // Snapshot slot written only when a checkpoint is actually allocated
    always_comb begin
        snap_d = snap_q;
        if (alloc_s) begin
            snap_d[tail_s] = ckpt_tbl_s;
        end else begin
            snap_d = snap_q;
        end
    end

    // Table and snapshot state; reset restores the identity map everywhere
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_AREGS; i++) begin
                table_q[i] <= preg_t'(i);
                for (int c = 0; c < NUM_CKPTS; c++) begin
                    snap_q[c][i] <= preg_t'(i);
                end
            end
        end else begin
            table_q <= table_d;
            snap_q  <= snap_d;
        end
    end

    rat_ckpt_ctrl u_ctrl (
        .clk             (clk),
        .rst             (rst),
        .fire_i          (rif.rn_fire),
        .any_req_i       (|rif.rn_ckpt_req),
        .release_i       (rif.ckpt_release),
        .restore_valid_i (rif.restore_valid),
        .restore_id_i    (rif.restore_id),
        .ready_o         (ready_s),
        .alloc_o         (alloc_s),
        .head_o          (head_s),
        .tail_o          (tail_s),
        .count_o         (count_s)
    );

    assign rif.rn_src_preg = src_flat_s;
    assign rif.rn_old_preg = old_flat_s;
    assign rif.rn_ready    = ready_s;
    assign rif.rn_ckpt_id  = tail_s;
    assign rif.ckpt_count  = count_s;

`ifdef RAT_ASSERT_EN
    rat_ckpt_chk u_chk (
        .clk           (clk),
        .rst           (rst),
        .fire          (rif.rn_fire),
        .ready         (ready_s),
        .ckpt_req      (rif.rn_ckpt_req),
        .ckpt_release  (rif.ckpt_release),
        .restore_valid (rif.restore_valid),
        .restore_id    (rif.restore_id),
        .head          (head_s),
        .count         (count_s),
        .dst_wen       (rif.rn_dst_wen),
        .new_preg      (rif.rn_new_preg),
        .table_i       (table_q)
    );
`endif
endmodule

// File: tb/tb_rat_ckpt.sv
// Directed scoreboard bench for rat_ckpt: expectations queued with stimulus, checked mid-cycle.
module tb_rat_ckpt;
    import rat_ckpt_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rat_ckpt_if rif ();
    rat_ckpt dut (.clk(clk), .rst(rst), .rif(rif));

    localparam int K_SRC = 0, K_OLD = 1, K_RDY = 2, K_CNT = 3, K_CID = 4;

    typedef struct {
        string       tag;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic idle();
        rif.rn_fire       = 1'b0;
        rif.rn_src_areg   = '0;
        rif.rn_dst_wen    = '0;
        rif.rn_dst_areg   = '0;
        rif.rn_new_preg   = '0;
        rif.rn_ckpt_req   = '0;
        rif.ckpt_release  = 1'b0;
        rif.restore_valid = 1'b0;
        rif.restore_id    = '0;
    endtask

    task automatic src(int lane, int slot, int areg);
        rif.rn_src_areg[(lane*2+slot)*AW +: AW] = areg_t'(areg);
    endtask

    task automatic dst(int lane, logic wen, int areg, int preg);
        rif.rn_dst_wen[lane]          = wen;
        rif.rn_dst_areg[lane*AW +: AW] = areg_t'(areg);
        rif.rn_new_preg[lane*PW +: PW] = preg_t'(preg);
    endtask

    task automatic req(int lane);
        rif.rn_ckpt_req[lane] = 1'b1;
    endtask

    task automatic restore(int id, logic rel);
        rif.restore_valid = 1'b1;
        rif.restore_id    = ckpt_id_t'(id);
        rif.ckpt_release  = rel;
    endtask

    task automatic expect_v(string tag, int kind, int idx, int exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = 32'(exp);
        sb.push_back(e);
    endtask

    task automatic rd(string tag, int lane, int slot, int areg, int exp);
        src(lane, slot, areg);
        expect_v(tag, K_SRC, lane*2+slot, exp);
    endtask

    function automatic logic [31:0] observe(int kind, int idx);
        case (kind)
            K_SRC:   return 32'(rif.rn_src_preg[idx*PW +: PW]);
            K_OLD:   return 32'(rif.rn_old_preg[idx*PW +: PW]);
            K_RDY:   return 32'(rif.rn_ready);
            K_CNT:   return 32'(rif.ckpt_count);
            K_CID:   return 32'(rif.rn_ckpt_id);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic chk();
        exp_t        e;
        logic [31:0] obs;
        @(negedge clk);
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind, e.idx);
            n_vec++;
            assert (obs === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and plain lookups
        rd("rst_a5", 0, 0, 5, 5);
        rd("rst_a31", 0, 1, 31, 31);
        rd("rst_l1_a0", 1, 0, 0, 0);
        rd("rst_l1_a17", 1, 1, 17, 17);
        dst(0, 1'b0, 9, 0);
        expect_v("rst_old9", K_OLD, 0, 9);
        req(0);
        expect_v("rst_ready", K_RDY, 0, 1);
        expect_v("rst_count", K_CNT, 0, 0);
        expect_v("rst_cid", K_CID, 0, 0);
        chk(); tick();

        // Same-group RAW bypass
        dst(0, 1'b1, 3, 40);
        src(1, 0, 3); src(1, 1, 4);
        dst(1, 1'b0, 3, 0);
        expect_v("byp_src3", K_SRC, 2, 40);
        expect_v("byp_src4", K_SRC, 3, 4);
        expect_v("byp_old1", K_OLD, 1, 40);
        expect_v("byp_old0", K_OLD, 0, 3);
        rif.rn_fire = 1'b1;
        chk(); tick();
        rd("tbl3", 0, 0, 3, 40);
        chk(); tick();

        // Both lanes write areg7: highest lane wins
        dst(0, 1'b1, 7, 41); dst(1, 1'b1, 7, 42);
        expect_v("waw_old1", K_OLD, 1, 41);
        expect_v("waw_old0", K_OLD, 0, 7);
        rif.rn_fire = 1'b1;
        chk(); tick();
        rd("tbl7", 0, 0, 7, 42);
        chk(); tick();

        // Fill all checkpoint slots
        for (int i = 0; i < 4; i++) begin
            dst(1, 1'b1, 10 + i, 44 + i);
            req(1);
            expect_v("fill_cid", K_CID, 0, i);
            expect_v("fill_cnt", K_CNT, 0, i);
            expect_v("fill_rdy", K_RDY, 0, 1);
            rif.rn_fire = 1'b1;
            chk(); tick();
        end
        req(0);
        expect_v("full_br_rdy", K_RDY, 0, 0);
        expect_v("full_cnt", K_CNT, 0, 4);
        chk(); tick();
        dst(0, 1'b1, 14, 48);
        expect_v("full_nobr_rdy", K_RDY, 0, 1);
        rif.rn_fire = 1'b1;
        chk(); tick();
        expect_v("full_cnt2", K_CNT, 0, 4);
        chk();
        rif.ckpt_release = 1'b1;
        tick();
        req(1);
        expect_v("rel_rdy", K_RDY, 0, 1);
        expect_v("rel_cid_wrap", K_CID, 0, 0);
        expect_v("rel_cnt", K_CNT, 0, 3);
        chk(); tick();

        // Restore slot 2 together with a release: head 1->2, count 1, tail 3
        restore(2, 1'b1);
        tick();
        expect_v("rr_cnt", K_CNT, 0, 1);
        expect_v("rr_cid", K_CID, 0, 3);
        rd("rr_a13", 0, 0, 13, 13);
        rd("rr_a12", 0, 1, 12, 46);
        rd("rr_a14", 1, 0, 14, 14);
        chk(); tick();

        // Checkpoint on lane 0 sees only lane 0's write
        dst(0, 1'b1, 2, 50); req(0); dst(1, 1'b1, 2, 51);
        expect_v("br_cid", K_CID, 0, 3);
        rif.rn_fire = 1'b1;
        chk(); tick();
        expect_v("br_cnt", K_CNT, 0, 2);
        rd("br_a2", 0, 0, 2, 51);
        chk(); tick();
        dst(0, 1'b1, 2, 52);
        rif.rn_fire = 1'b1;
        tick();
        rd("br_a2b", 0, 0, 2, 52);
        chk(); tick();
        restore(3, 1'b0);
        tick();
        rd("rs_a2", 0, 0, 2, 50);
        rd("rs_a12", 0, 1, 12, 46);
        expect_v("rs_cnt", K_CNT, 0, 2);
        expect_v("rs_cid", K_CID, 0, 0);
        chk(); tick();

        // Restore discards a concurrent rename group
        restore(3, 1'b0);
        dst(0, 1'b1, 9, 60); req(1);
        rif.rn_fire = 1'b1;
        tick();
        rd("rsf_a9", 0, 0, 9, 9);
        expect_v("rsf_cnt", K_CNT, 0, 2);
        expect_v("rsf_cid", K_CID, 0, 0);
        chk(); tick();

        // Drain, then a release on empty must be ignored
        rif.ckpt_release = 1'b1; tick();
        rif.ckpt_release = 1'b1; tick();
        rif.ckpt_release = 1'b1; tick();
        expect_v("empty_cnt", K_CNT, 0, 0);
        chk(); tick();
        dst(1, 1'b1, 20, 61); req(1);
        expect_v("post_cid", K_CID, 0, 0);
        rif.rn_fire = 1'b1;
        chk(); tick();
        expect_v("post_cnt", K_CNT, 0, 1);
        chk();
        restore(0, 1'b0);
        tick();
        expect_v("head_cnt", K_CNT, 0, 1);
        expect_v("head_cid", K_CID, 0, 1);
        rd("head_a20", 0, 0, 20, 61);
        chk(); tick();

        // Reset dominates a concurrent rename
        rst = 1'b1;
        dst(0, 1'b1, 5, 62);
        rif.rn_fire = 1'b1;
        tick();
        rst = 1'b0;
        rd("rst2_a5", 0, 0, 5, 5);
        rd("rst2_a20", 0, 1, 20, 20);
        expect_v("rst2_cnt", K_CNT, 0, 0);
        expect_v("rst2_cid", K_CID, 0, 0);
        chk(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rat_ckpt.md
Name: rat_ckpt

Overview:
- Register alias table for the rename stage, parametrised in lane count and checkpoint depth.
- Maps architectural to physical registers for RENAME_WIDTH lanes per cycle.
- Resolves dependencies between lanes of the same rename group.
- Returns each destination's previous mapping for freelist/ROB release.
- Keeps NUM_CKPTS branch snapshots for single-cycle misprediction recovery.

Parameters:
- NUM_AREGS, 32: architectural registers; AW = $clog2(NUM_AREGS).
- NUM_PREGS, 64: physical registers; PW = $clog2(NUM_PREGS).
- RENAME_WIDTH, 2: lanes per group (1..4).
- NUM_CKPTS, 4: snapshot slots, power of 2; CW = $clog2(NUM_CKPTS).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- rn_fire  in  1  rename group accepted this cycle; may only be high while rn_ready=1.
- rn_ready  out  1  group can be accepted: checkpoint available, or no lane requests one.
- rn_src_areg  in  RENAME_WIDTH*2*AW  two source aregs per lane.
- rn_src_preg  out  RENAME_WIDTH*2*PW  source mappings, combinational.
- rn_dst_wen  in  RENAME_WIDTH  lane writes a destination.
- rn_dst_areg  in  RENAME_WIDTH*AW  destination areg.
- rn_new_preg  in  RENAME_WIDTH*PW  newly allocated preg.
- rn_old_preg  out  RENAME_WIDTH*PW  prior mapping of dst, combinational.
- rn_ckpt_req  in  RENAME_WIDTH  lane is a branch; at most one bit set per group.
- rn_ckpt_id  out  CW  slot assigned to the requesting lane (the tail).
- ckpt_release  in  1  oldest checkpoint's branch resolved correctly.
- restore_valid  in  1  mispredict recovery.
- restore_id  in  CW  checkpoint to restore.
- ckpt_count  out  CW+1  live checkpoints.

Behaviour:
- Reset state:
  - table[i] = i.
  - head = tail = 0, count = 0.
  - rn_ready = 1, ckpt_count = 0.
  - Reset dominates all other inputs.
- Reads are combinational from the registered table plus intra-group bypass:
  - Lane k's source and old-dst lookups see the youngest writing lane j<k with a matching dst_areg; otherwise the table.
  - Lane 0 never bypasses.
- Write commit on rn_fire, effective next cycle:
  - Every wen lane updates the table.
  - When lanes share a dst, the highest lane wins.
  - Areg 0 is renamed like any other register; no special case.
- Checkpoint on rn_fire with rn_ckpt_req[k]:
  - snap[tail] = table state after applying writes of lanes 0..k only.
  - tail++ modulo NUM_CKPTS; count++.
  - rn_ckpt_id = tail before the increment.
- Ready rule: rn_ready = !(count == NUM_CKPTS && |rn_ckpt_req).
  - Groups without branches proceed while full.
  - rn_fire with rn_ready=0 is illegal.
- ckpt_release: head++ and count--.
  - Ignored when count == 0.
- restore_valid:
  - Next cycle table = snap[restore_id].
  - tail = restore_id + 1, modulo NUM_CKPTS; slot restore_id itself stays live until released.
  - count = (restore_id - head) mod NUM_CKPTS + 1.
  - rn_fire in the same cycle is discarded entirely: no writes, no checkpoint.
- Restore and release in the same cycle:
  - Release is applied first (head++); count is then recomputed from the new head.
  - restore_id == old head with release is illegal.
- Wrap-around: head/tail wrap modulo NUM_CKPTS.
  - count distinguishes full from empty.

Optional Feature:
- RAT_ASSERT_EN defined: simulation-only concurrent assertions, each firing $error:
  - rn_fire while !rn_ready.
  - More than one rn_ckpt_req bit set.
  - ckpt_release with count == 0.
  - restore_id not live.
  - rn_new_preg < NUM_AREGS written while it is still mapped in the table.
- RAT_ASSERT_EN undefined: no assertion code; identical RTL behaviour.

Decomposition:
- CORE_PKG gains NUM_CKPTS and the typedefs areg_t, preg_t, ckpt_id_t.
- Sub-module rat_ckpt_ctrl: head/tail/count pointer logic, rn_ready, and restore/release arbitration.
- Table, bypass and snapshot arrays remain in rat_ckpt.

Test Plan:
- Reset, then read aregs 5 and 31 on lane 0 -> rn_src_preg = 5, 31; ckpt_count = 0; rn_ready = 1.
- Lane0 wen areg3 -> preg40, lane1 src areg3, same group -> lane1 src = 40, lane1 old dst as lookup; next cycle table[3] = 40.
- Lane0 and lane1 both write areg7 (preg41, preg42) -> lane1 rn_old_preg = 41; next cycle table[7] = 42.
- Lane0 writes areg2 -> preg50 with ckpt_req; lane1 writes areg2 -> preg51; next cycle areg2 -> preg52; restore_id = 0 -> table[2] = 50; ckpt_count = 1.
- Four branch groups fill all slots -> rn_ready = 0 on a fifth branch but 1 for a non-branch group; one ckpt_release -> rn_ready = 1 and the new id wraps to 0.
- Restore concurrent with rn_fire writing areg9 -> preg60 -> table[9] is unchanged from the snapshot; no checkpoint is allocated.
